// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Each requester has a one-entry registered response slot with valid/ready draining.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    input  logic [NUM_REQ*4-1:0]   req_ctrl,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [3:0]             alu_ctrl,
    input  logic [31:0]            alu_result,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [NUM_REQ*32-1:0]  resp_data,
    output logic [CNT_W-1:0]       op_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [NUM_REQ*32-1:0] resp_data_q, resp_data_d;
    logic [CNT_W-1:0]      op_count_q, op_count_d;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [IDX_W:0]        cand;
    logic [IDX_W-1:0]      cand_idx;

    // A slot holding an unconsumed result may only be refilled if it drains this cycle.
    always_comb begin
        eligible  = req_valid & (~resp_valid_q | resp_ready);
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            cand_idx = cand[IDX_W-1:0];
            if (!grant_any && eligible[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                grant_any       = 1'b1;
            end
        end
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_a    = req_a[32*i +: 32];
                alu_b    = req_b[32*i +: 32];
                alu_ctrl = req_ctrl[4*i +: 4];
            end
        end
    end

    // Grant is a subset of req_valid, so a grant is always an accept.
    always_comb begin
        resp_valid_d = (resp_valid_q & ~resp_ready) | grant;
        resp_data_d  = resp_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                resp_data_d[32*i +: 32] = alu_result;
            end
        end
        last_grant_d = grant_any ? grant_idx : last_grant_q;
        op_count_d   = grant_any ? op_count_q + CNT_W'(1) : op_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IDX_W'(NUM_REQ-1);
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            op_count_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req_ready  = grant;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios plus randomized traffic
// against a behavioural model; a second instance with CNT_W=4 exercises counter wrap.
module tb_alu_rr_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req_valid, resp_ready;
    logic [N*32-1:0] req_a, req_b;
    logic [N*4-1:0]  req_ctrl;

    logic [N-1:0]    req_ready, resp_valid;
    logic [31:0]     alu_a, alu_b, alu_result;
    logic [3:0]      alu_ctrl;
    logic [N*32-1:0] resp_data;
    logic [15:0]     op_count;

    logic [N-1:0]    req_ready2, resp_valid2;
    logic [31:0]     alu_a2, alu_b2, alu_result2;
    logic [3:0]      alu_ctrl2;
    logic [N*32-1:0] resp_data2;
    logic [3:0]      op_count2;

    int tests_run    = 0;
    int tests_failed = 0;

    // Shared ALU model: a fixed operation table standing in for the execute-stage ALU.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        case (c)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign alu_result  = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_result2 = alu_fn(alu_a2, alu_b2, alu_ctrl2);

    alu_rr_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .op_count(op_count)
    );

    alu_rr_arbiter #(.NUM_REQ(N), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_ctrl(alu_ctrl2), .alu_result(alu_result2),
        .resp_valid(resp_valid2), .resp_ready(resp_ready), .resp_data(resp_data2),
        .op_count(op_count2)
    );

    // Reference model state: who was served last, the response slots and the op total.
    int          m_last;
    logic [N-1:0] m_rv;
    logic [31:0] m_rd [N];
    int          m_cnt;
    logic [N-1:0] exp_grant;
    int          exp_idx;
    logic [31:0] exp_a, exp_b, exp_res;
    logic [3:0]  exp_c;

    task automatic model_eval();
        bit elig [N];
        exp_grant = '0;
        exp_idx   = -1;
        exp_a = '0; exp_b = '0; exp_c = '0;
        for (int i = 0; i < N; i++) elig[i] = req_valid[i] && (!m_rv[i] || resp_ready[i]);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (exp_idx < 0 && elig[j]) exp_idx = j;
        end
        if (exp_idx >= 0) begin
            exp_grant[exp_idx] = 1'b1;
            exp_a = req_a[32*exp_idx +: 32];
            exp_b = req_b[32*exp_idx +: 32];
            exp_c = req_ctrl[4*exp_idx +: 4];
        end
        exp_res = alu_fn(exp_a, exp_b, exp_c);
    endtask

    task automatic model_commit();
        if (rst) begin
            m_last = N - 1;
            m_rv   = '0;
            for (int i = 0; i < N; i++) m_rd[i] = '0;
            m_cnt  = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (exp_grant[i]) begin
                    m_rd[i] = exp_res;
                    m_rv[i] = 1'b1;
                end else if (resp_ready[i]) begin
                    m_rv[i] = 1'b0;
                end
            end
            if (exp_idx >= 0) begin
                m_last = exp_idx;
                m_cnt  = m_cnt + 1;
            end
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_ctrl[4*i +: 4] = c;
    endtask

    task automatic tick_pre();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick_post();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; resp_ready = '0;
        tick_pre(); tick_post();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; resp_ready = '0;
        req_a = '0; req_b = '0; req_ctrl = '0;
        tick_pre(); tick_post();
        tick_pre(); tick_post();
        rst = 1'b0;
        tick_pre();
        tests_run++; if (resp_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_resp_valid got %b want 0000", resp_valid); end
        tests_run++; if (resp_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_resp_data got %h want 0", resp_data); end
        tests_run++; if (op_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_op_count got %0d want 0", op_count); end
        tests_run++; if (op_count2 !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_op_count_small got %0d want 0", op_count2); end
        tests_run++; if (req_ready !== 4'b0000 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'h0)
            begin tests_failed++; $display("[TB] FAIL idle_alu got ready=%b a=%h b=%h c=%h want all zero", req_ready, alu_a, alu_b, alu_ctrl); end
        tick_post();
    endtask

    task automatic test_single_add();
        req_valid = 4'b0001; resp_ready = '0;
        set_op(0, 32'd5, 32'd3, 4'h0);
        tick_pre();
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("[TB] FAIL add_ready got %b want 0001", req_ready); end
        tests_run++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_ctrl !== 4'h0)
            begin tests_failed++; $display("[TB] FAIL add_alu_in got a=%0d b=%0d c=%h want 5 3 0", alu_a, alu_b, alu_ctrl); end
        tick_post();
        req_valid = '0;
        tick_pre();
        tests_run++; if (resp_valid !== 4'b0001) begin tests_failed++; $display("[TB] FAIL add_resp_valid got %b want 0001", resp_valid); end
        tests_run++; if (resp_data[31:0] !== 32'd8) begin tests_failed++; $display("[TB] FAIL add_resp_data got %0d want 8", resp_data[31:0]); end
        tests_run++; if (op_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL add_op_count got %0d want 1", op_count); end
        tick_post();
    endtask

    task automatic test_rotation();
        logic [N-1:0] want;
        do_reset();
        req_valid = 4'b1111; resp_ready = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom, 4'($urandom_range(0, 4)));
            want = 4'b0001 << (c % 4);
            tick_pre();
            tests_run++; if (req_ready !== want) begin tests_failed++; $display("[TB] FAIL rotate_ready cyc%0d got %b want %b", c, req_ready, want); end
            tests_run++; if (op_count !== 16'(c)) begin tests_failed++; $display("[TB] FAIL rotate_op_count cyc%0d got %0d want %0d", c, op_count, c); end
            for (int i = 0; i < N; i++) begin
                tests_run++; if (resp_data[32*i +: 32] !== m_rd[i]) begin tests_failed++; $display("[TB] FAIL rotate_data%0d got %h want %h", i, resp_data[32*i +: 32], m_rd[i]); end
            end
            tick_post();
        end
        req_valid = '0;
        tick_pre();
        for (int i = 0; i < N; i++) begin
            tests_run++; if (resp_data[32*i +: 32] !== m_rd[i]) begin tests_failed++; $display("[TB] FAIL rotate_final%0d got %h want %h", i, resp_data[32*i +: 32], m_rd[i]); end
        end
        tick_post();
    endtask

    task automatic test_blocked();
        do_reset();
        req_valid = 4'b0010; resp_ready = '0;
        set_op(1, 32'd7, 32'd2, 4'h0);
        tick_pre(); tick_post();
        set_op(1, 32'd10, 32'd4, 4'h1);
        tick_pre();
        tests_run++; if (resp_valid !== 4'b0010) begin tests_failed++; $display("[TB] FAIL blocked_held got %b want 0010", resp_valid); end
        tests_run++; if (req_ready !== 4'b0000 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'h0)
            begin tests_failed++; $display("[TB] FAIL blocked_stall got ready=%b a=%h b=%h c=%h want all zero", req_ready, alu_a, alu_b, alu_ctrl); end
        tick_post();
        resp_ready = 4'b0010;
        tick_pre();
        tests_run++; if (req_ready !== 4'b0010 || alu_a !== 32'd10) begin tests_failed++; $display("[TB] FAIL blocked_release got ready=%b a=%0d want 0010 10", req_ready, alu_a); end
        tick_post();
        req_valid = '0; resp_ready = '0;
        tick_pre();
        tests_run++; if (resp_valid[1] !== 1'b1 || resp_data[63:32] !== 32'd6)
            begin tests_failed++; $display("[TB] FAIL blocked_result got v=%b d=%0d want 1 6", resp_valid[1], resp_data[63:32]); end
        tick_post();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 4'b0100; resp_ready = '0;
        set_op(2, 32'd1, 32'd1, 4'h0);
        tick_pre(); tick_post();
        set_op(2, 32'hF0, 32'h3C, 4'h2);
        resp_ready = 4'b0100;
        tick_pre();
        tests_run++; if (req_ready !== 4'b0100 || alu_ctrl !== 4'h2) begin tests_failed++; $display("[TB] FAIL b2b_accept got ready=%b c=%h want 0100 2", req_ready, alu_ctrl); end
        tick_post();
        req_valid = '0; resp_ready = '0;
        tick_pre();
        tests_run++; if (resp_valid !== 4'b0100) begin tests_failed++; $display("[TB] FAIL b2b_valid got %b want 0100", resp_valid); end
        tests_run++; if (resp_data[95:64] !== 32'h30) begin tests_failed++; $display("[TB] FAIL b2b_data got %h want 30", resp_data[95:64]); end
        tick_post();
    endtask

    task automatic test_reset_override();
        req_valid = 4'b1000; resp_ready = '0;
        set_op(3, 32'd9, 32'd9, 4'h0);
        rst = 1'b1;
        tick_pre();
        tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("[TB] FAIL rstov_grant got %b want 1000", req_ready); end
        tick_post();
        rst = 1'b0;
        req_valid = 4'b1001;
        tick_pre();
        tests_run++; if (resp_valid !== 4'b0000 || op_count !== 16'd0 || op_count2 !== 4'd0)
            begin tests_failed++; $display("[TB] FAIL rstov_state got v=%b cnt=%0d cnt4=%0d want 0000 0 0", resp_valid, op_count, op_count2); end
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("[TB] FAIL rstov_priority got %b want 0001", req_ready); end
        tick_post();
        req_valid = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rst        = ($urandom_range(0, 49) == 0);
            req_valid  = 4'($urandom);
            resp_ready = 4'($urandom);
            for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom, 4'($urandom_range(0, 7)));
            tick_pre();
            tests_run++; if (req_ready !== exp_grant) begin tests_failed++; $display("[TB] FAIL rand_ready cyc%0d got %b want %b", c, req_ready, exp_grant); end
            tests_run++; if (alu_a !== exp_a || alu_b !== exp_b || alu_ctrl !== exp_c)
                begin tests_failed++; $display("[TB] FAIL rand_alu cyc%0d got %h %h %h want %h %h %h", c, alu_a, alu_b, alu_ctrl, exp_a, exp_b, exp_c); end
            tests_run++; if (resp_valid !== m_rv) begin tests_failed++; $display("[TB] FAIL rand_valid cyc%0d got %b want %b", c, resp_valid, m_rv); end
            for (int i = 0; i < N; i++) begin
                tests_run++; if (resp_data[32*i +: 32] !== m_rd[i]) begin tests_failed++; $display("[TB] FAIL rand_data%0d cyc%0d got %h want %h", i, c, resp_data[32*i +: 32], m_rd[i]); end
            end
            tests_run++; if (op_count !== 16'(m_cnt) || op_count2 !== 4'(m_cnt))
                begin tests_failed++; $display("[TB] FAIL rand_count cyc%0d got %0d/%0d want %0d", c, op_count, op_count2, m_cnt); end
            tick_post();
        end
        rst = 1'b0;
        req_valid = '0;
        resp_ready = '0;
    endtask

    task automatic test_op_count_wrap();
        do_reset();
        req_valid = 4'b0001; resp_ready = 4'b0001;
        for (int c = 0; c < 17; c++) begin
            set_op(0, $urandom, $urandom, 4'h0);
            tick_pre(); tick_post();
        end
        req_valid = '0;
        tick_pre();
        tests_run++; if (op_count2 !== 4'd1) begin tests_failed++; $display("[TB] FAIL wrap_small got %0d want 1", op_count2); end
        tests_run++; if (op_count !== 16'd17) begin tests_failed++; $display("[TB] FAIL wrap_wide got %0d want 17", op_count); end
        tick_post();
    endtask

    initial begin
        m_last = N - 1; m_rv = '0; m_cnt = 0;
        for (int i = 0; i < N; i++) m_rd[i] = '0;
        test_reset();
        test_single_add();
        test_rotation();
        test_blocked();
        test_back_to_back();
        test_reset_override();
        test_random();
        test_op_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
